lock_key_loader: RTL and testbench

- Sequential key-delivery block for the RLL-locked combinational netlists generated by this codebase.
- Receives the secret key serially from an external key store or programming port, followed by an 8-bit checksum.
- On a checksum match, drives the verified key onto the locked circuit's keyIn_0_* inputs; an invalid or partial key never reaches them.
- Sits between the chip's key port and the locked netlist; the locked netlist itself stays purely combinational.

---
 rtl/lock_key_loader.sv | 135 +++++++++++++
 tb/tb_lock_key_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key loader for RLL-locked netlists: shifts in key + XOR checksum, commits only verified keys.
// Optional one-time-programming lock enabled by defining LOCK_KEY_OTP_EN.
module lock_key_loader #(
    parameter int                   KEY_WIDTH = 32,
    parameter logic [KEY_WIDTH-1:0] RESET_KEY = {KEY_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 sdi,
    input  logic                 sdi_valid,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 load_done,
    output logic                 load_err,
    output logic                 busy
`ifdef LOCK_KEY_OTP_EN
    ,
    output logic                 otp_locked
`endif
);

    localparam int FRAME_W = KEY_WIDTH + 8;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 key_valid_q;
    logic                 done_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 ready_q;
    logic                 load_block_s;

    function automatic logic [7:0] xor_bytes(input logic [KEY_WIDTH-1:0] k);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < KEY_WIDTH / 8; i++) begin
            acc = acc ^ k[8*i +: 8];
        end
        return acc;
    endfunction

`ifdef LOCK_KEY_OTP_EN
    logic otp_q;
    assign load_block_s = otp_q;
    assign otp_locked   = otp_q;
`else
    assign load_block_s = 1'b0;
`endif

    // Frame arrives LSB-first into a right-shifting register, so after the last bit
    // the key sits in the low KEY_WIDTH bits and the checksum in the top byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            frame_q     <= {FRAME_W{1'b0}};
            key_q       <= RESET_KEY;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
`ifdef LOCK_KEY_OTP_EN
            otp_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start && !load_block_s) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= {CNT_W{1'b0}};
                        frame_q <= {FRAME_W{1'b0}};
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (load_start) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        frame_q <= {FRAME_W{1'b0}};
                    end else if (sdi_valid) begin
                        frame_q <= {sdi, frame_q[FRAME_W-1:1]};
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_CHECK;
                            ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (xor_bytes(frame_q[KEY_WIDTH-1:0]) == frame_q[FRAME_W-1 -: 8]) begin
                        key_q       <= frame_q[KEY_WIDTH-1:0];
                        key_valid_q <= 1'b1;
                        done_q      <= 1'b1;
`ifdef LOCK_KEY_OTP_EN
                        otp_q       <= 1'b1;
`endif
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sdi_ready = ready_q;
    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader: bit-queue reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours LOCK_KEY_OTP_EN when defined.
module tb_lock_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        sdi = 1'b0;
    logic        sdi_valid = 1'b0;
    logic        sdi_ready;
    logic [31:0] key_out;
    logic        key_valid;
    logic        load_done;
    logic        load_err;
    logic        busy;
`ifdef LOCK_KEY_OTP_EN
    logic        otp_locked;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    lock_key_loader #(.KEY_WIDTH(32), .RESET_KEY(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .sdi_ready  (sdi_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .load_done  (load_done),
        .load_err   (load_err),
        .busy       (busy)
`ifdef LOCK_KEY_OTP_EN
        ,
        .otp_locked (otp_locked)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: collects accepted bits in a queue, judges the frame one cycle after it completes.
    logic [31:0] m_key = 32'h0;
    bit          m_valid = 1'b0, m_done = 1'b0, m_err = 1'b0;
    bit          m_loading = 1'b0, m_judging = 1'b0, m_otp = 1'b0;
    bit          m_bits[$];
    logic [31:0] mk;
    logic [7:0]  mc;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_key = 32'h0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
                m_loading = 1'b0; m_judging = 1'b0; m_otp = 1'b0;
                m_bits.delete();
            end else begin
                m_done = 1'b0;
                m_err  = 1'b0;
                if (m_judging) begin
                    mk = 32'h0;
                    mc = 8'h0;
                    for (int i = 0; i < 32; i++) if (m_bits[i]) mk = mk + (32'h1 << i);
                    for (int i = 0; i < 8; i++)  if (m_bits[32+i]) mc = mc + (8'h1 << i);
                    if ((mk[7:0] ^ mk[15:8] ^ mk[23:16] ^ mk[31:24]) == mc) begin
                        m_key = mk; m_valid = 1'b1; m_done = 1'b1;
`ifdef LOCK_KEY_OTP_EN
                        m_otp = 1'b1;
`endif
                    end else begin
                        m_err = 1'b1;
                    end
                    m_judging = 1'b0;
                end else if (m_loading) begin
                    if (load_start) begin
                        m_bits.delete();
                    end else if (sdi_valid) begin
                        m_bits.push_back(sdi);
                        if (m_bits.size() == 40) begin
                            m_loading = 1'b0;
                            m_judging = 1'b1;
                        end
                    end
                end else if (load_start && !m_otp) begin
                    m_loading = 1'b1;
                    m_bits.delete();
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("cyc_key_out",   {32'h0, key_out},   {32'h0, m_key});
                chk("cyc_key_valid", {63'h0, key_valid}, {63'h0, m_valid});
                chk("cyc_load_done", {63'h0, load_done}, {63'h0, m_done});
                chk("cyc_load_err",  {63'h0, load_err},  {63'h0, m_err});
                chk("cyc_busy",      {63'h0, busy},      {63'h0, m_loading | m_judging});
                chk("cyc_sdi_ready", {63'h0, sdi_ready}, {63'h0, m_loading});
`ifdef LOCK_KEY_OTP_EN
                chk("cyc_otp",       {63'h0, otp_locked}, {63'h0, m_otp});
`endif
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; sdi_valid = 1'b0; load_start = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic start();
        @(negedge clk); load_start = 1'b1; sdi_valid = 1'b0;
        @(negedge clk); load_start = 1'b0;
    endtask

    task automatic send_bits(input logic [39:0] val, input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gaps)) begin
                @(negedge clk); sdi_valid = 1'b0; sdi = ~sdi;
            end
            @(negedge clk); sdi_valid = 1'b1; sdi = val[i];
        end
    endtask

    task automatic send_frame(input logic [31:0] key, input logic [7:0] cs, input int gaps);
        send_bits({cs, key}, 40, gaps);
    endtask

    // One CHECK cycle after the last bit, then the result pulse.
    task automatic expect_result(input bit ok, input bit ls_in_check);
        @(negedge clk); sdi_valid = 1'b0; load_start = ls_in_check;
        chk("chk_busy",  {63'h0, busy},      64'h1);
        chk("chk_ready", {63'h0, sdi_ready}, 64'h0);
        chk("chk_early", {63'h0, load_done | load_err}, 64'h0);
        @(negedge clk); load_start = 1'b0;
        chk("res_done", {63'h0, load_done}, {63'h0, ok});
        chk("res_err",  {63'h0, load_err},  {63'h0, !ok});
        chk("res_busy", {63'h0, busy},      64'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_key",   {32'h0, key_out},   64'h0);
        chk("rst_valid", {63'h0, key_valid}, 64'h0);
        chk("rst_ready", {63'h0, sdi_ready}, 64'h0);
        chk("rst_busy",  {63'h0, busy},      64'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Happy path
        start();
        send_frame(32'h1234_5678, 8'h08, 0);
        expect_result(1'b1, 1'b0);
        chk("happy_key",   {32'h0, key_out},   64'h1234_5678);
        chk("happy_valid", {63'h0, key_valid}, 64'h1);

        // Bad checksum from reset
        do_reset();
        start();
        send_frame(32'h1234_5678, 8'h09, 0);
        expect_result(1'b0, 1'b0);
        chk("bad_key",   {32'h0, key_out},   64'h0);
        chk("bad_valid", {63'h0, key_valid}, 64'h0);

`ifndef LOCK_KEY_OTP_EN
        // Failed reload keeps the old key; load_start during CHECK is ignored
        do_reset();
        start();
        send_frame(32'h1234_5678, 8'h08, 0);
        expect_result(1'b1, 1'b0);
        start();
        send_frame(32'hAABB_CCDD, 8'h01, 1);
        expect_result(1'b0, 1'b1);
        chk("reload_key",   {32'h0, key_out},   64'h1234_5678);
        chk("reload_valid", {63'h0, key_valid}, 64'h1);
        @(negedge clk);
        chk("check_ls_ignored", {63'h0, busy}, 64'h0);
`endif

        // Gapped input with abort after 10 bits
        do_reset();
        start();
        send_bits(40'h00_DEAD_BEEF, 10, 3);
        @(negedge clk); load_start = 1'b1; sdi_valid = 1'b1; sdi = 1'b1;
        @(negedge clk); load_start = 1'b0; sdi_valid = 1'b0;
        send_frame(32'h0F1E_2D3C, 8'h00, 3);
        expect_result(1'b1, 1'b0);
        chk("abort_key", {32'h0, key_out}, 64'h0F1E_2D3C);

        // Asynchronous reset mid-load
        start();
        send_bits(40'h00_5555_AAAA, 20, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_key",   {32'h0, key_out},   64'h0);
        chk("arst_valid", {63'h0, key_valid}, 64'h0);
        chk("arst_busy",  {63'h0, busy},      64'h0);
        chk("arst_ready", {63'h0, sdi_ready}, 64'h0);
        chk("arst_pulse", {63'h0, load_done | load_err}, 64'h0);
        @(negedge clk); sdi_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

`ifdef LOCK_KEY_OTP_EN
        // One-time-programmed: second load is ignored
        start();
        send_frame(32'h1234_5678, 8'h08, 0);
        expect_result(1'b1, 1'b0);
        chk("otp_set", {63'h0, otp_locked}, 64'h1);
        start();
        chk("otp_ready", {63'h0, sdi_ready}, 64'h0);
        send_frame(32'hCAFE_F00D, 8'hC9, 0);
        repeat (3) @(negedge clk);
        sdi_valid = 1'b0;
        chk("otp_key",  {32'h0, key_out},    64'h1234_5678);
        chk("otp_hold", {63'h0, otp_locked}, 64'h1);
        chk("otp_busy", {63'h0, busy},       64'h0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
